// File: rtl/seq101_pkg.sv
// Shared definitions for the time-multiplexed "101" detector scheduler:
// detector state encoding and the Moore next-state / detection helpers.
package seq101_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,  // nothing useful seen
    S1 = 2'd1,  // last bit was 1
    S2 = 2'd2,  // last bits were 1,0
    S3 = 2'd3   // last bits were 1,0,1 -> detection
  } det_state_e;

  // Next detector state for one input bit; overlapping detection.
  function automatic det_state_e ns101(input det_state_e state, input logic x);
    det_state_e nxt;
    nxt = S0;
    case (state)
      S0: nxt = x ? S1 : S0;
      S1: nxt = x ? S1 : S2;
      S2: nxt = x ? S3 : S0;
      S3: nxt = x ? S1 : S2;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  // A state reports a detection when the full "101" has been seen.
  function automatic logic is_hit(input det_state_e state);
    return state == S3;
  endfunction

endpackage

// File: rtl/seq101_sched_rr_arb.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted channel and wraps modulo NCH; no eligible channel -> no grant.
module rr_arb #(
  parameter int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] elig,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] gnt_idx
);

  // Pick the first eligible channel after ptr in circular order.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned, which would otherwise infer a latch.
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NCH;
      if (!found && elig[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = CHW'(idx);
      end
    end
  end

endmodule

// File: rtl/seq101_sched.sv
// One shared "101" detector datapath time-multiplexed across NCH serial
// requesters. Each channel's detector state lives in a context register;
// the granted channel's state is advanced and a tagged result issued a
// cycle later.
module seq101_sched
  import seq101_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,    // asynchronous, active-low
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] x,
  input  logic [NCH-1:0] clr,
  output logic [NCH-1:0] gnt,
  output logic           y_vld,
  output logic [CHW-1:0] y_ch,
  output logic           y,
  output logic [NCH-1:0] hit
);

  det_state_e     ctx_q [NCH];
  logic [CHW-1:0] ptr_q;
  logic           y_vld_q;
  logic [CHW-1:0] y_ch_q;
  logic           y_q;
  logic [NCH-1:0] hit_q;

  logic [NCH-1:0] elig;
  logic [CHW-1:0] gnt_idx;
  logic           xfer;
  det_state_e     cur_s;
  det_state_e     nxt_s;

  // A channel being cleared this cycle is masked from arbitration.
  assign elig = req & ~clr;

  rr_arb #(.NCH(NCH)) u_arb (
    .elig    (elig),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Shared next-state datapath on the granted channel's saved context.
  assign xfer  = |gnt;
  assign cur_s = ctx_q[gnt_idx];
  assign nxt_s = ns101(cur_s, x[gnt_idx]);

  // Context file, pointer, clears and registered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the context file is reset, not left uninitialised, because
      // every channel must restart its detector from S0 after reset.
      for (int i = 0; i < NCH; i++) ctx_q[i] <= S0;
      ptr_q   <= CHW'(NCH - 1);
      y_vld_q <= 1'b0;
      y_ch_q  <= '0;
      y_q     <= 1'b0;
      hit_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the clear loop and the
      // transfer update below all see pre-edge values and never race.
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          ctx_q[i] <= S0;
          hit_q[i] <= 1'b0;
        end
      end
      // A granted channel is never being cleared, so these never collide.
      if (xfer) begin
        ctx_q[gnt_idx] <= nxt_s;
        ptr_q          <= gnt_idx;
        y_vld_q        <= 1'b1;
        y_ch_q         <= gnt_idx;
        y_q            <= is_hit(nxt_s);
        if (is_hit(nxt_s)) hit_q[gnt_idx] <= 1'b1;
      end else begin
        y_vld_q <= 1'b0;
      end
    end
  end

  assign y_vld = y_vld_q;
  assign y_ch  = y_ch_q;
  assign y     = y_q;
  assign hit   = hit_q;

endmodule

// File: tb/tb_seq101_sched.sv
// Self-checking bench for seq101_sched: directed scenarios plus randomized
// traffic, checked by a scoreboard fed from a last-three-bits reference model.
module tb_seq101_sched;

  localparam int NCH = 4;
  localparam int CHW = $clog2(NCH);

  logic           clk;
  logic           rst;
  logic [NCH-1:0] req;
  logic [NCH-1:0] x;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] gnt;
  logic           y_vld;
  logic [CHW-1:0] y_ch;
  logic           y;
  logic [NCH-1:0] hit;

  seq101_sched #(.NCH(NCH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .x     (x),
    .clr   (clr),
    .gnt   (gnt),
    .y_vld (y_vld),
    .y_ch  (y_ch),
    .y     (y),
    .hit   (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: each channel remembers its last three accepted bits
  // and how many it has accepted since reset/clear; a hit is "101".
  logic [2:0]     m_hist [NCH];
  int             m_cnt  [NCH];
  logic [NCH-1:0] m_hit;
  int             m_last;      // last granted channel
  int             m_gnt_ch;    // channel granted in the current cycle, -1 none
  int             exp_q [$];   // pending results: ch*2 + y

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_hist[i] = '0;
      m_cnt[i]  = 0;
    end
    m_hit  = '0;
    m_last = NCH - 1;
    exp_q.delete();
  endtask

  // Apply one cycle of stimulus, check the combinational grant and predict
  // the effect of the coming clock edge.
  task automatic cycle(input logic [NCH-1:0] r, input logic [NCH-1:0] xv,
                       input logic [NCH-1:0] c);
    logic [NCH-1:0] eg;
    logic           yb;
    @(negedge clk);
    req = r; x = xv; clr = c;
    #1;
    eg = '0;
    m_gnt_ch = -1;
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = (m_last + k) % NCH;
      if (m_gnt_ch < 0 && r[idx] && !c[idx]) m_gnt_ch = idx;
    end
    if (m_gnt_ch >= 0) eg[m_gnt_ch] = 1'b1;
    check("gnt", 32'(gnt), 32'(eg));
    for (int i = 0; i < NCH; i++) begin
      if (c[i]) begin
        m_hist[i] = '0;
        m_cnt[i]  = 0;
        m_hit[i]  = 1'b0;
      end
    end
    if (m_gnt_ch >= 0) begin
      m_hist[m_gnt_ch] = {m_hist[m_gnt_ch][1:0], xv[m_gnt_ch]};
      if (m_cnt[m_gnt_ch] < 3) m_cnt[m_gnt_ch]++;
      yb = (m_cnt[m_gnt_ch] >= 3) && (m_hist[m_gnt_ch] == 3'b101);
      if (yb) m_hit[m_gnt_ch] = 1'b1;
      exp_q.push_back(m_gnt_ch * 2 + int'(yb));
      m_last = m_gnt_ch;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; x = '0; clr = '0;
    rst = 1'b0;
    #1;
    check("rst_y_vld", 32'(y_vld), 32'd0);
    check("rst_y_ch",  32'(y_ch),  32'd0);
    check("rst_y",     32'(y),     32'd0);
    check("rst_hit",   32'(hit),   32'd0);
    check("rst_gnt",   32'(gnt),   32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: after every edge, match presented results against the queue.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      if (y_vld) begin
        if (exp_q.size() == 0) begin
          check("spurious_y_vld", 32'd1, 32'd0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("y_ch", 32'(y_ch), 32'(e >> 1));
          check("y",    32'(y),    32'(e & 1));
        end
      end else if (exp_q.size() != 0) begin
        check("missing_y_vld", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
      check("hit", 32'(hit), 32'(m_hit));
    end
  end

  logic [NCH-1:0] pend, xb, cl;

  initial begin
    rst = 1'b0; req = '0; x = '0; clr = '0;
    model_reset();
    do_reset();

    // ch0 alone: 1,0,1,0,1 -> y 0,0,1,0,1
    cycle(4'b0001, 4'b0001, '0);
    cycle(4'b0001, 4'b0000, '0);
    cycle(4'b0001, 4'b0001, '0);
    cycle(4'b0001, 4'b0000, '0);
    cycle(4'b0001, 4'b0001, '0);
    cycle('0, '0, '0);

    // All channels requesting from reset: strict rotation.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(4'b1111, 4'(i * 5), '0);
    cycle('0, '0, '0);

    // Context isolation: ch1 sends 1,0,1, ch2 sends 1,1,1, interleaved.
    do_reset();
    cycle(4'b0010, 4'b0010, '0);
    cycle(4'b0100, 4'b0100, '0);
    cycle(4'b0010, 4'b0000, '0);
    cycle(4'b0100, 4'b0100, '0);
    cycle(4'b0010, 4'b0010, '0);
    cycle(4'b0100, 4'b0100, '0);
    cycle('0, '0, '0);

    // Clear priority: ch1 at S2, clear with a concurrent x=1 request.
    do_reset();
    cycle(4'b0010, 4'b0010, '0);
    cycle(4'b0010, 4'b0000, '0);
    cycle(4'b0010, 4'b0010, 4'b0010);
    cycle(4'b0010, 4'b0010, '0);
    // Clear of ch3 alongside a grant to ch0.
    cycle(4'b0001, 4'b0001, 4'b1000);
    cycle('0, '0, '0);

    // Reset mid-stream with ch0 at S2, then x=1 gives no hit.
    cycle(4'b0001, 4'b0001, '0);
    cycle(4'b0001, 4'b0000, '0);
    do_reset();
    cycle(4'b1001, 4'b0001, '0);
    cycle(4'b1000, 4'b0000, '0);

    // Idle for 5 cycles, then rotation resumes after the last grant.
    for (int i = 0; i < 5; i++) cycle('0, '0, '0);
    cycle(4'b1111, 4'b1111, '0);
    cycle(4'b1111, 4'b1111, '0);

    // Randomized traffic: requesters hold req/x until granted.
    pend = '0; xb = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!pend[i]) begin
          pend[i] = ($urandom_range(3) != 0);
          xb[i]   = 1'($urandom_range(1));
        end
        cl[i] = ($urandom_range(15) == 0);
      end
      cycle(pend, xb, cl);
      if (m_gnt_ch >= 0) pend[m_gnt_ch] = 1'b0;
    end

    cycle('0, '0, '0);
    cycle('0, '0, '0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
